// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith ops plus an iterative shift-add
// unsigned multiply, all delivered through one registered valid/ready result port.
`timescale 1ns/1ps

module alu_exec_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inValid,
    output logic             inReady,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] resultHi,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1000;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   resultHi_q, resultHi_d;
    logic               zero_q, zero_d;
    logic               overflow_q, overflow_d;
    logic               illegal_q, illegal_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      count_q, count_d;

    logic [WIDTH-1:0]   sumAB, diffAB, aluRes;
    logic               aluOv, aluIll;
    logic [WIDTH:0]     stepSum;
    logic [2*WIDTH-1:0] stepAcc;
    logic               startOp;

    always_comb begin
        sumAB  = operandA + operandB;
        diffAB = operandA - operandB;
        aluRes = '0;
        aluOv  = 1'b0;
        aluIll = 1'b0;
        unique case (operation)
            OP_AND: aluRes = operandA & operandB;
            OP_OR:  aluRes = operandA | operandB;
            OP_NOR: aluRes = ~(operandA | operandB);
            OP_ADD: begin
                aluRes = sumAB;
                aluOv  = (operandA[WIDTH-1] == operandB[WIDTH-1]) &&
                         (sumAB[WIDTH-1] != operandA[WIDTH-1]);
            end
            OP_SUB: begin
                aluRes = diffAB;
                aluOv  = (operandA[WIDTH-1] != operandB[WIDTH-1]) &&
                         (diffAB[WIDTH-1] != operandA[WIDTH-1]);
            end
            // Differing signs decide SLT directly, so a wrapped difference never misleads it.
            OP_SLT: begin
                if (operandA[WIDTH-1] != operandB[WIDTH-1])
                    aluRes = {{(WIDTH-1){1'b0}}, operandA[WIDTH-1]};
                else
                    aluRes = {{(WIDTH-1){1'b0}}, diffAB[WIDTH-1]};
            end
            default: aluIll = 1'b1;
        endcase
    end

    // One shift-add step: conditionally add the multiplicand into the upper half, then shift right.
    always_comb begin
        stepSum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        stepAcc = {stepSum, acc_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        resultHi_d = resultHi_q;
        zero_d     = zero_q;
        overflow_d = overflow_q;
        illegal_d  = illegal_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        count_d    = count_q;
        inReady    = 1'b0;
        startOp    = 1'b0;

        case (state_q)
            IDLE: begin
                inReady = 1'b1;
                startOp = inValid;
            end
            MUL: begin
                acc_d    = stepAcc;
                mplier_d = mplier_q >> 1;
                count_d  = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    result_d   = stepAcc[WIDTH-1:0];
                    resultHi_d = stepAcc[2*WIDTH-1:WIDTH];
                    zero_d     = (stepAcc[WIDTH-1:0] == '0);
                    overflow_d = 1'b0;
                    illegal_d  = 1'b0;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                inReady = outReady;
                if (outReady) begin
                    if (inValid) startOp = 1'b1;
                    else         state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (startOp) begin
            if (operation == OP_MUL) begin
                mcand_d  = operandA;
                mplier_d = operandB;
                acc_d    = '0;
                count_d  = CW'(WIDTH);
                state_d  = MUL;
            end else begin
                result_d   = aluRes;
                resultHi_d = '0;
                zero_d     = (aluRes == '0);
                overflow_d = aluOv;
                illegal_d  = aluIll;
                state_d    = HOLD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            result_q   <= '0;
            resultHi_q <= '0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            resultHi_q <= resultHi_d;
            zero_q     <= zero_d;
            overflow_q <= overflow_d;
            illegal_q  <= illegal_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            count_q    <= count_d;
        end
    end

    assign outValid = (state_q == HOLD);
    assign result   = result_q;
    assign resultHi = resultHi_q;
    assign zero     = zero_q;
    assign overflow = overflow_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed corner cases followed by random
// operations compared against an arithmetic reference model.
`timescale 1ns/1ps

module tb_alu_exec_unit;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         inValid = 1'b0;
    logic         inReady;
    logic [3:0]   operation = 4'd0;
    logic [W-1:0] operandA = '0;
    logic [W-1:0] operandB = '0;
    logic         outValid;
    logic         outReady = 1'b1;
    logic [W-1:0] result;
    logic [W-1:0] resultHi;
    logic         zero;
    logic         overflow;
    logic         illegal;

    int testsRun = 0;
    int failCount = 0;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inValid   (inValid),
        .inReady   (inReady),
        .operation (operation),
        .operandA  (operandA),
        .operandB  (operandB),
        .outValid  (outValid),
        .outReady  (outReady),
        .result    (result),
        .resultHi  (resultHi),
        .zero      (zero),
        .overflow  (overflow),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference: plain integer arithmetic straight from the operation table.
    function automatic void refModel(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                     output logic [W-1:0] r, output logic [W-1:0] hi,
                                     output logic ov, output logic ill);
        int sa = $signed(a);
        int sb = $signed(b);
        int s;
        logic [63:0] p;
        r = '0; hi = '0; ov = 1'b0; ill = 1'b0;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b1100: r = ~(a | b);
            4'b0010: begin s = sa + sb; r = s[W-1:0]; ov = (s > 32767) || (s < -32768); end
            4'b0110: begin s = sa - sb; r = s[W-1:0]; ov = (s > 32767) || (s < -32768); end
            4'b0111: r = (sa < sb) ? 16'd1 : 16'd0;
            4'b1000: begin p = {48'd0, a} * {48'd0, b}; r = p[15:0]; hi = p[31:16]; end
            default: ill = 1'b1;
        endcase
    endfunction

    // Presents an op at a falling edge and holds it until the rising edge that accepts it.
    task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int waitCycles = 0;
        @(negedge clk);
        operation = op;
        operandA  = a;
        operandB  = b;
        inValid   = 1'b1;
        while (!inReady && waitCycles < 40) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!inReady) checkOutput("acceptTimeout", 32'(inReady), 32'd1);
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    task automatic checkResult(input string tag, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r, hi;
        logic ov, ill;
        refModel(op, a, b, r, hi, ov, ill);
        checkOutput({tag, ".outValid"}, 32'(outValid), 32'd1);
        checkOutput({tag, ".result"},   32'(result),   32'(r));
        checkOutput({tag, ".resultHi"}, 32'(resultHi), 32'(hi));
        checkOutput({tag, ".zero"},     32'(zero),     32'(r == '0));
        checkOutput({tag, ".overflow"}, 32'(overflow), 32'(ov));
        checkOutput({tag, ".illegal"},  32'(illegal),  32'(ill));
    endtask

    task automatic runOp(input string tag, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int lat = 0;
        applyStimulus(op, a, b);
        do begin
            @(negedge clk);
            lat++;
        end while (!outValid && lat < 40);
        checkOutput({tag, ".latency"}, 32'(lat), (op == 4'b1000) ? 32'(W + 1) : 32'd1);
        checkResult(tag, op, a, b);
    endtask

    initial begin
        logic [3:0] codes [8];
        logic [3:0] op;
        int badCycles;
        int staleValid;
        codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1000, 4'b0000};

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("reset.outValid", 32'(outValid), 32'd0);
        checkOutput("reset.inReady",  32'(inReady),  32'd1);
        checkOutput("reset.result",   32'(result),   32'd0);
        checkOutput("reset.resultHi", 32'(resultHi), 32'd0);
        checkOutput("reset.zero",     32'(zero),     32'd0);
        checkOutput("reset.overflow", 32'(overflow), 32'd0);
        checkOutput("reset.illegal",  32'(illegal),  32'd0);
        rst_n = 1'b1;

        // Directed arithmetic and logic cases
        runOp("add7fff", 4'b0010, 16'h7FFF, 16'h0001);
        checkOutput("add7fff.const", {15'd0, overflow, result}, {15'd0, 1'b1, 16'h8000});
        runOp("subEq", 4'b0110, 16'h0005, 16'h0005);
        checkOutput("subEq.const", {zero, overflow, result}, {1'b1, 1'b0, 16'h0000});
        runOp("sltNeg", 4'b0111, 16'hFFFF, 16'h0001);
        checkOutput("sltNeg.const", 32'(result), 32'd1);
        runOp("sltOvf", 4'b0111, 16'h8000, 16'h7FFF);
        checkOutput("sltOvf.const", 32'(result), 32'd1);
        runOp("nor", 4'b1100, 16'h00FF, 16'h0F00);
        checkOutput("nor.const", 32'(result), 32'h0000F000);
        runOp("and", 4'b0000, 16'hF0F0, 16'hFF00);
        checkOutput("and.const", 32'(result), 32'h0000F000);

        // Multiply: stall window, ignored inputs while busy, then the product
        applyStimulus(4'b1000, 16'hFFFF, 16'hFFFF);
        badCycles = 0;
        for (int k = 1; k <= W; k++) begin
            @(negedge clk);
            if (inReady !== 1'b0 || outValid !== 1'b0) badCycles++;
            inValid   = (k < W);
            operation = 4'b0000;
            operandA  = W'($urandom);
            operandB  = W'($urandom);
        end
        checkOutput("mul.stallCycles", 32'(badCycles), 32'd0);
        @(negedge clk);
        checkOutput("mul.outValid", 32'(outValid), 32'd1);
        checkOutput("mul.product",  {resultHi, result}, 32'hFFFE0001);
        checkOutput("mul.zero",     32'(zero), 32'd0);

        // Reset while a multiply is running
        applyStimulus(4'b1000, 16'h1234, 16'h5678);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midReset.outValid", 32'(outValid), 32'd0);
        checkOutput("midReset.inReady",  32'(inReady),  32'd1);
        checkOutput("midReset.result",   32'(result),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        staleValid = 0;
        repeat (25) begin
            @(negedge clk);
            if (outValid !== 1'b0) staleValid++;
        end
        checkOutput("midReset.noStale", 32'(staleValid), 32'd0);

        // Backpressure then a back-to-back accept in the consuming cycle
        outReady = 1'b0;
        applyStimulus(4'b0001, 16'h1200, 16'h0034);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("hold.result",   32'(result),   32'h00001234);
            checkOutput("hold.inReady",  32'(inReady),  32'd0);
            checkOutput("hold.outValid", 32'(outValid), 32'd1);
        end
        outReady  = 1'b1;
        operation = 4'b0010;
        operandA  = 16'd2;
        operandB  = 16'd3;
        inValid   = 1'b1;
        #1;
        checkOutput("b2b.inReady", 32'(inReady), 32'd1);
        @(posedge clk);
        #1;
        inValid = 1'b0;
        checkOutput("b2b.outValid", 32'(outValid), 32'd1);
        checkOutput("b2b.result",   32'(result),   32'd5);
        @(negedge clk);

        // Illegal codes, then a legal op clears the flag
        runOp("ill0011", 4'b0011, 16'hABCD, 16'h1234);
        checkOutput("ill0011.const", {illegal, zero, result}, {1'b1, 1'b1, 16'h0000});
        runOp("ill1111", 4'b1111, 16'hFFFF, 16'hFFFF);
        checkOutput("ill1111.const", {illegal, zero, result}, {1'b1, 1'b1, 16'h0000});
        runOp("clearIll", 4'b0001, 16'h0001, 16'h0000);
        checkOutput("clearIll.const", 32'(illegal), 32'd0);

        // Random operations against the reference model
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) op = 4'($urandom_range(0, 15));
            else                           op = codes[$urandom_range(0, 6)];
            runOp($sformatf("rand%0d", n), op, W'($urandom), W'($urandom));
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU. Consumes the 4-bit operation code produced by ALU control, plus two operands.
- Single-cycle logic ops and iterative multiply share one registered result port with a valid/ready handshake.
- Sits between ID/EX operand latching and the EX/MEM register.
- Stalls the pipeline through inReady while a multiply is in progress.

Parameters:
- WIDTH, 16, operand and result width in bits; must be ≥4.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- inValid  input  1  operation, operandA and operandB are valid this cycle
- inReady  output  1  unit can accept a new operation
- operation  input  4  ALU control code (encoding below)
- operandA  input  WIDTH  first operand
- operandB  input  WIDTH  second operand
- outValid  output  1  result, resultHi and flags are valid
- outReady  input  1  downstream accepts the result
- result  output  WIDTH  result (multiply: low half of product)
- resultHi  output  WIDTH  multiply: high half of product; 0 for all other ops
- zero  output  1  result == 0
- overflow  output  1  signed overflow (ADD/SUB only)
- illegal  output  1  operation code not in encoding table

Behaviour:
- Encoding:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB
  - 0111 SLT (signed; result 1 or 0), 1100 NOR
  - 1000 MUL (unsigned, multi-cycle)
  - All other codes are illegal.
- Reset (async, rst_n low): state IDLE; result, resultHi, zero, overflow, illegal, outValid = 0; inReady = 1; multiply accumulator/counter cleared. Reset mid-multiply aborts the multiply; no result is ever presented for it.
- FSM states: IDLE, MUL, HOLD.
- IDLE:
  - inReady=1. Accept when inValid && inReady.
  - Single-cycle op or illegal code: register outputs, go to HOLD; outValid=1 the next cycle (latency 1).
  - MUL: latch operands, clear the 2*WIDTH accumulator, load counter = WIDTH, go to MUL.
- MUL:
  - inReady=0. One shift-add step per cycle (add operandA to upper half if multiplier LSB set, shift right).
  - When counter reaches 0, load result/resultHi, go to HOLD. outValid rises WIDTH+1 cycles after accept.
- HOLD:
  - outValid=1; outputs stable.
  - inReady = outReady. The unit may accept a new op in the same cycle the current result is consumed.
  - outValid && outReady with a new accept: behave as IDLE accept (back-to-back single-cycle ops give one result per cycle).
  - outValid && outReady without a new accept: go to IDLE, outValid=0.
  - outReady=0: remain in HOLD; outputs held indefinitely.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH.
  - ADD overflow = operand signs equal and result sign differs.
  - SUB overflow = operand signs differ and result sign differs from operandA.
  - overflow=0 for all other ops.
- SLT uses signed comparison and is correct across overflow (compare signs first).
- zero is computed from result only, including MUL.
- Illegal: result=0, resultHi=0, zero=1, overflow=0, illegal=1; completes like a single-cycle op.
- operation and operand inputs are ignored unless inValid && inReady.

Test Plan:
- Reset asserted mid-MUL (cycle 5 of 16) → outValid=0, inReady=1, result=0 immediately (async); no stale result after release.
- WIDTH=16; ADD 0x7FFF+0x0001 → one cycle after accept: result=0x8000, overflow=1, zero=0. SUB 0x0005-0x0005 → result=0, zero=1, overflow=0.
- SLT 0xFFFF vs 0x0001 → result=1. SLT 0x8000 vs 0x7FFF → result=1. NOR 0x00FF,0x0F00 → 0xF000. AND 0xF0F0,0xFF00 → 0xF000.
- MUL 0xFFFF×0xFFFF accepted at cycle T → inReady=0 for cycles T+1..T+16; outValid at T+17 with result=0x0001, resultHi=0xFFFE.
- Backpressure: hold outReady=0 for 5 cycles after OR 0x1200|0x0034 → result stays 0x1234, inReady=0. Raise outReady with a new ADD 2+3 presented → next cycle result=5, outValid stays continuously 1.
- Illegal codes 0011 and 1111 → illegal=1, result=0, zero=1, latency 1. Next legal op clears illegal.
